spi_cmd_sched: RTL and testbench

//  Command scheduler sitting directly upstream of the SPI master. Buffers 16-bit SPI frames in a

---
 rtl/spi_cmd_sched_pkg.sv | 16 +
 rtl/spi_cmd_fifo.sv | 59 +++++
 rtl/spi_cmd_sched.sv | 111 +++++++++++
 tb/tb_spi_cmd_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_sched_pkg.sv
// Shared types and constants for the SPI command scheduler.
// One-hot FSM encoding and the legal SPI mode values.
package spi_cmd_sched_pkg;

  localparam logic [1:0] SPI_MODE1 = 2'd1;
  localparam logic [1:0] SPI_MODE3 = 2'd3;

  localparam int FRAME_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_ISSUE = 3'b010,
    S_WAIT  = 3'b100
  } state_t;

endpackage

// File: rtl/spi_cmd_fifo.sv
// Synchronous command FIFO for SPI frames.
// Head word is registered into dout on pop and held otherwise.
module spi_cmd_fifo
  import spi_cmd_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = FRAME_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // a full FIFO refuses pushes even if a pop frees a slot this cycle
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      dout   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      unique case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_sched.sv
// Command scheduler upstream of the SPI master: FIFO, issue FSM,
// frame timeout and a one-entry response register.
module spi_cmd_sched
  import spi_cmd_sched_pkg::*;
#(
  parameter int         DEPTH   = 8,
  parameter int         TIMEOUT = 50000,
  parameter logic [1:0] MODE    = 2'd3
) (
  input  logic                   sys_clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [15:0]            cmd_data,
  output logic [$clog2(DEPTH):0] cmd_level,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_data,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   spi_en,
  output logic [1:0]             spi_mode,
  output logic [15:0]            spi_sdata,
  input  logic [15:0]            spi_rdata,
  input  logic                   spi_done
);

  localparam int TW = $clog2(TIMEOUT);

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;
  logic          timer_hit;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          in_wait;

  spi_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (16)
  ) u_fifo (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .pop   (fifo_pop),
    .din   (cmd_data),
    .dout  (spi_sdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (cmd_level)
  );

  assign cmd_ready = ~fifo_full;
  assign spi_mode  = MODE;
  assign timer_hit = (timer == TW'(TIMEOUT - 1));
  assign in_wait   = (state == S_WAIT);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (!fifo_empty && !rsp_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  if (spi_done || timer_hit) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // an unconsumed response holds off the next frame
  always_comb begin
    fifo_pop = (state == S_IDLE) && !fifo_empty && !rsp_valid;
    busy     = (state != S_IDLE);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_en    <= 1'b0;
      timer     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (state == S_ISSUE) begin
        spi_en <= 1'b1;
        timer  <= '0;
      end else if (in_wait) begin
        timer <= timer + 1'b1;
      end
      // done wins over a coincident timeout
      if (in_wait && spi_done) begin
        rsp_data  <= spi_rdata;
        rsp_err   <= 1'b0;
        rsp_valid <= 1'b1;
        spi_en    <= 1'b0;
      end else if (in_wait && timer_hit) begin
        rsp_data  <= '0;
        rsp_err   <= 1'b1;
        rsp_valid <= 1'b1;
        spi_en    <= 1'b0;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_sched.sv
// Scoreboard bench for spi_cmd_sched with a behavioural SPI master.
// Expected responses are queued at push time and checked on handshake.
module tb_spi_cmd_sched;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 100;

  logic        sys_clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_data;
  logic [3:0]  cmd_level;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        spi_en;
  logic [1:0]  spi_mode;
  logic [15:0] spi_sdata;
  logic [15:0] spi_rdata;
  logic        spi_done;

  spi_cmd_sched #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .MODE    (2'd3)
  ) dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .cmd_level (cmd_level),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .spi_en    (spi_en),
    .spi_mode  (spi_mode),
    .spi_sdata (spi_sdata),
    .spi_rdata (spi_rdata),
    .spi_done  (spi_done)
  );

  always #10 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;

  logic [16:0] exp_q[$];
  logic [15:0] iss_q[$];

  int          done_dly  = 5;
  bit          no_done   = 1'b0;
  bit          use_fixed = 1'b0;
  logic [15:0] fixed_val = 16'h0;

  function automatic logic [15:0] rfn(input logic [15:0] s);
    return s ^ 16'h5A5A;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    @(posedge sys_clk);
    #1 cmd_valid = 1'b0;
    iss_q.push_back(d);
    if (no_done)        exp_q.push_back({1'b1, 16'h0});
    else if (use_fixed) exp_q.push_back({1'b0, fixed_val});
    else                exp_q.push_back({1'b0, rfn(d)});
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || busy || cmd_level != 0) && n < max) begin
      tick(1);
      n++;
    end
    check("drain_done", 32'(n < max), 32'd1);
  endtask

  task automatic wait_en(input int max);
    int n = 0;
    while (!spi_en && n < max) begin
      tick(1);
      n++;
    end
    check("wait_spi_en", 32'(spi_en), 32'd1);
  endtask

  // response monitor: compare on every handshake
  always @(negedge sys_clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got err=%0b data=%h expected none",
                 rsp_err, rsp_data);
      end else begin
        check("rsp", {15'd0, rsp_err, rsp_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  // behavioural SPI master
  int          wcnt = 0;
  logic [15:0] frame_sd;
  bit          frame_nd = 1'b0;
  bit          done_chk = 1'b0;

  initial begin
    spi_done  = 1'b0;
    spi_rdata = 16'h0;
    forever begin
      @(negedge sys_clk);
      if (done_chk) begin
        check("done_to_rsp", 32'(rsp_valid), 32'd1);
        done_chk = 1'b0;
      end
      spi_done = 1'b0;
      if (!rst_n) begin
        wcnt = 0;
      end else if (spi_en) begin
        if (wcnt == 0) begin
          frame_nd = no_done;
          frame_sd = spi_sdata;
          if (iss_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_frame: got %h expected none", spi_sdata);
          end else begin
            check("issue_order", 32'(spi_sdata), 32'(iss_q.pop_front()));
          end
        end else begin
          check("sdata_stable", 32'(spi_sdata), 32'(frame_sd));
        end
        wcnt++;
        if (!frame_nd && wcnt == done_dly) begin
          spi_done  = 1'b1;
          spi_rdata = use_fixed ? fixed_val : rfn(spi_sdata);
          done_chk  = 1'b1;
        end
      end else begin
        if (wcnt > 0 && frame_nd) check("timeout_len", 32'(wcnt), 32'(TIMEOUT));
        wcnt = 0;
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 16'h0;
    rsp_ready = 1'b1;
    tick(3);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_level",     32'(cmd_level), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_spi_en",    32'(spi_en),    32'd0);
    check("rst_sdata",     32'(spi_sdata), 32'd0);
    check("spi_mode",      32'(spi_mode),  32'd3);
    rst_n = 1'b1;
    tick(2);

    // single frame, fixed reply after 40 cycles, issue latency
    done_dly  = 40;
    use_fixed = 1'b1;
    fixed_val = 16'h1234;
    check("t1_ready", 32'(cmd_ready), 32'd1);
    push(16'hA55A);
    check("t1_lat0", 32'(spi_en), 32'd0);
    tick(1);
    check("t1_lat1", 32'(spi_en), 32'd0);
    tick(1);
    check("t1_lat2", 32'(spi_en), 32'd1);
    drain(200);
    use_fixed = 1'b0;

    // fill FIFO while a frame is in flight, blocked push when full
    done_dly = 30;
    push(16'h1000);
    wait_en(10);
    for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i));
    check("t2_level_full", 32'(cmd_level), 32'd8);
    check("t2_ready_full", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1;
    cmd_data  = 16'hDEAD;
    tick(1);
    cmd_valid = 1'b0;
    check("t2_blocked_push", 32'(cmd_level), 32'd8);
    drain(1000);

    // response backpressure
    done_dly  = 5;
    rsp_ready = 1'b0;
    push(16'h3001);
    push(16'h3002);
    push(16'h3003);
    tick(30);
    check("t3_busy_idle", 32'(busy),      32'd0);
    check("t3_level",     32'(cmd_level), 32'd2);
    check("t3_rsp_held",  32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    tick(1);
    check("t3_rsp_clear",  32'(rsp_valid), 32'd0);
    check("t3_still_idle", 32'(busy),      32'd0);
    tick(1);
    check("t3_resume_busy",  32'(busy),      32'd1);
    check("t3_resume_level", 32'(cmd_level), 32'd1);
    drain(200);

    // timeout, then a normal frame
    no_done = 1'b1;
    push(16'h4444);
    push(16'h5555);
    drain(500);
    no_done = 1'b0;
    push(16'h6666);
    drain(200);

    // done coincident with the last timer cycle
    done_dly = TIMEOUT;
    push(16'h7777);
    drain(300);

    // reset mid-frame with words queued
    done_dly = 60;
    for (int i = 0; i < 5; i++) push(16'h8000 + 16'(i));
    wait_en(10);
    tick(10);
    check("t6_level_pre", 32'(cmd_level), 32'd4);
    rst_n = 1'b0;
    #1;
    check("t6_spi_en",    32'(spi_en),    32'd0);
    check("t6_level",     32'(cmd_level), 32'd0);
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_busy",      32'(busy),      32'd0);
    check("t6_ready",     32'(cmd_ready), 32'd1);
    exp_q.delete();
    iss_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(200);
    check("t6_no_stale_rsp", 32'(rsp_valid), 32'd0);
    check("t6_no_frame",     32'(spi_en),    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
